// File: rtl/id_ex_stage_reg_pkg.sv
// Processor-wide constants for the ID/EX stage: widths, ALU op codes,
// stage state encodings and the EX payload carried by the pipeline register.
package id_ex_stage_reg_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned REG_AW = 3;
   localparam int unsigned OP_W   = 5;

   typedef enum logic [OP_W-1:0] {
      ALU_ADD  = 5'h00,
      ALU_SUB  = 5'h01,
      ALU_AND  = 5'h02,
      ALU_OR   = 5'h03,
      ALU_PASS = 5'h04,
      ALU_XOR  = 5'h05,
      ALU_SLL  = 5'h06,
      ALU_SRL  = 5'h07
   } alu_op_e;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } stage_state_e;

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] pc2;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
      logic [OP_W-1:0]   alu_op;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              halt;
   } ex_payload_t;

   // A bubble carries no live control and zeroed data.
   localparam ex_payload_t EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Load-use hazard detector: an ID instruction reads the destination of a
// load that is still in EX. Shared later with the forwarding unit.
module id_ex_stage_reg_load_use_detect
   import id_ex_stage_reg_pkg::*;
(
   input  logic              id_valid_i,
   input  logic              id_uses_rs_i,
   input  logic              id_uses_rt_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic              ex_valid_i,
   input  logic              ex_mem_read_i,
   input  logic              ex_reg_write_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   output logic              hz_o
);

   logic rs_match;
   logic rt_match;

   assign rs_match = id_uses_rs_i & (id_rs_i == ex_rd_i);
   assign rt_match = id_uses_rt_i & (id_rt_i == ex_rd_i);
   assign hz_o     = id_valid_i & ex_valid_i & ex_mem_read_i & ex_reg_write_i
                     & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, flush, downstream
// stall hold, sticky HALT state and a saturating bubble counter.
module id_ex_stage_reg
   import id_ex_stage_reg_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_pc2,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [OP_W-1:0]   id_alu_op,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              id_mem_write,
   input  logic              id_halt,
   input  logic              flush,
   input  logic              ex_stall,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_pc2,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [REG_AW-1:0] ex_rs,
   output logic [REG_AW-1:0] ex_rt,
   output logic [REG_AW-1:0] ex_rd,
   output logic [OP_W-1:0]   ex_alu_op,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_halt,
   output logic              stall_up,
   output logic              halted,
   output logic [CNT_W-1:0]  bubble_count
);

   ex_payload_t  ex_q;
   ex_payload_t  payload_d;
   stage_state_e state_q;
   logic [CNT_W-1:0] bubble_cnt_q;
   logic         hz;

   id_ex_stage_reg_load_use_detect u_load_use_detect (
      .id_valid_i     (id_valid),
      .id_uses_rs_i   (id_uses_rs),
      .id_uses_rt_i   (id_uses_rt),
      .id_rs_i        (id_rs),
      .id_rt_i        (id_rt),
      .ex_valid_i     (ex_q.valid),
      .ex_mem_read_i  (ex_q.mem_read),
      .ex_reg_write_i (ex_q.reg_write),
      .ex_rd_i        (ex_q.rd),
      .hz_o           (hz)
   );

   // Captured ID slot; control bits are gated so an empty slot is inert.
   always_comb begin
      payload_d           = EX_BUBBLE;
      payload_d.valid     = id_valid;
      payload_d.pc2       = id_pc2;
      payload_d.rs_data   = id_rs_data;
      payload_d.rt_data   = id_rt_data;
      payload_d.imm       = id_imm;
      payload_d.rs        = id_rs;
      payload_d.rt        = id_rt;
      payload_d.rd        = id_rd;
      payload_d.alu_op    = id_alu_op;
      payload_d.reg_write = id_reg_write & id_valid;
      payload_d.mem_read  = id_mem_read  & id_valid;
      payload_d.mem_write = id_mem_write & id_valid;
      payload_d.halt      = id_halt      & id_valid;
   end

   // Priority: reset, flush, downstream stall, halted, load-use, capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q         <= EX_BUBBLE;
         state_q      <= ST_RUN;
         bubble_cnt_q <= '0;
      end else if (flush) begin
         ex_q <= EX_BUBBLE;
      end else if (ex_stall) begin
         ex_q <= ex_q;
      end else if (state_q == ST_HALTED) begin
         ex_q <= EX_BUBBLE;
      end else if (hz) begin
         ex_q <= EX_BUBBLE;
         if (bubble_cnt_q != {CNT_W{1'b1}}) begin
            bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
         end
      end else begin
         ex_q <= payload_d;
         if (payload_d.halt) begin
            state_q <= ST_HALTED;
         end
      end
   end

   assign stall_up     = ~flush & (ex_stall | hz | (state_q == ST_HALTED));
   assign halted       = (state_q == ST_HALTED);
   assign bubble_count = bubble_cnt_q;

   assign ex_valid     = ex_q.valid;
   assign ex_pc2       = ex_q.pc2;
   assign ex_rs_data   = ex_q.rs_data;
   assign ex_rt_data   = ex_q.rt_data;
   assign ex_imm       = ex_q.imm;
   assign ex_rs        = ex_q.rs;
   assign ex_rt        = ex_q.rt;
   assign ex_rd        = ex_q.rd;
   assign ex_alu_op    = ex_q.alu_op;
   assign ex_reg_write = ex_q.reg_write;
   assign ex_mem_read  = ex_q.mem_read;
   assign ex_mem_write = ex_q.mem_write;
   assign ex_halt      = ex_q.halt;

endmodule
